// File: rtl/en_decoder_if.sv
// Data bus between the link datapath and the SECDED(16,11) encoder.
// The master drives the raw data word; the encoder returns the codeword.
interface en_decoder_if;
    logic [15:0] d_in;
    logic [15:0] d_out;

    modport master (
        output d_in,
        input  d_out
    );

    modport slave (
        input  d_in,
        output d_out
    );
endinterface

// File: rtl/en_decoder.sv
// Extended-Hamming SECDED(16,11) transmit encoder with one output register.
// d_out[15:1] is the Hamming(15,11) code, d_out[0] the overall parity.
module en_decoder_top (
    input  logic        clk,
    input  logic        reset,
    en_decoder_if.slave bus
);

    logic [10:0] d;
    logic [4:0]  unused_hi;
    logic [15:0] code;

    assign d         = bus.d_in[10:0];
    assign unused_hi = bus.d_in[15:11];

    // Place payload bits and derive the four Hamming parities plus overall parity
    always_comb begin
        code     = '0;
        code[3]  = d[0];
        code[5]  = d[1];
        code[6]  = d[2];
        code[7]  = d[3];
        code[9]  = d[4];
        code[10] = d[5];
        code[11] = d[6];
        code[12] = d[7];
        code[13] = d[8];
        code[14] = d[9];
        code[15] = d[10];
        code[1]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        code[2]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        code[4]  = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        code[8]  = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        code[0]  = ^code[15:1];
    end

    // Output register; reset yields the all-zero codeword of data 0
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.d_out <= 16'h0000;
        end else begin
            bus.d_out <= code;
        end
    end

endmodule

// File: tb/tb_en_decoder_top.sv
// Self-checking bench for en_decoder_top: scoreboard of expected codewords
// from an independent positional Hamming model, plus code property checks.
module tb_en_decoder_top;

    logic clk;
    logic reset;

    en_decoder_if bus ();

    en_decoder_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests;
    int fails;
    logic [15:0] sb[$];
    logic [15:0] cw[2048];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic encoder: fill non-power-of-two positions in order, then
    // set each parity so every position group with bit k set XORs to 0.
    function automatic logic [15:0] model(input logic [15:0] v);
        logic [15:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = v[j];
                j++;
            end
        end
        for (int k = 1; k < 16; k = k * 2) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos & k) != 0) && (pos != k)) p = p ^ c[pos];
            c[k] = p;
        end
        c[0] = 1'b0;
        for (int pos = 1; pos < 16; pos++) c[0] = c[0] ^ c[pos];
        return c;
    endfunction

    task automatic drive_cycle(input logic [15:0] v, input logic r);
        @(negedge clk);
        bus.d_in = v;
        reset    = r;
        sb.push_back(r ? 16'h0000 : model(v));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(16'h07FF, 1'b1);
            exp = sb.pop_front();
            tests++;
            if (bus.d_out !== 16'h0000 || exp !== 16'h0000) begin
                fails++;
                $display("FAIL reset_hold%0d: got %h want %h", i, bus.d_out, 16'h0000);
            end
        end
        drive_cycle(16'h07FF, 1'b0);
        exp = sb.pop_front();
        tests++;
        if (bus.d_out !== 16'hFFFF) begin
            fails++;
            $display("FAIL reset_release: got %h want %h (model %h)", bus.d_out, 16'hFFFF, exp);
        end
    endtask

    task automatic test_nibble_sweep();
        logic [15:0] exp;
        logic [15:0] spot;
        for (int v = 0; v < 16; v++) begin
            drive_cycle(16'(v), 1'b0);
            exp = sb.pop_front();
            tests++;
            if (bus.d_out !== exp) begin
                fails++;
                $display("FAIL nibble_%0d: got %h want %h", v, bus.d_out, exp);
            end
            case (v)
                0:  spot = 16'h0000;
                1:  spot = 16'h000F;
                2:  spot = 16'h0033;
                15: spot = 16'h00FF;
                default: spot = exp;
            endcase
            if (v == 0 || v == 1 || v == 2 || v == 15) begin
                tests++;
                if (bus.d_out !== spot) begin
                    fails++;
                    $display("FAIL spot_%0d: got %h want %h", v, bus.d_out, spot);
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] vin[4];
        logic [15:0] want[4];
        logic [15:0] exp;
        vin[0] = 16'h07FF; want[0] = 16'hFFFF;
        vin[1] = 16'h0800; want[1] = 16'h0000;
        vin[2] = 16'hF801; want[2] = 16'h000F;
        vin[3] = 16'h0001; want[3] = 16'h000F;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(vin[i], 1'b0);
            exp = sb.pop_front();
            tests++;
            if (bus.d_out !== want[i] || exp !== want[i]) begin
                fails++;
                $display("FAIL extreme_%h: got %h want %h", vin[i], bus.d_out, want[i]);
            end
        end
        bus.d_in = 16'h0555;
        #2;
        tests++;
        if (bus.d_out !== 16'h000F) begin
            fails++;
            $display("FAIL mid_cycle_hold: got %h want %h", bus.d_out, 16'h000F);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic [15:0] o;
        int syn;
        int bad_match;
        int bad_par;
        int bad_syn;
        int bad_data;
        int md;
        int j;
        bad_match = 0; bad_par = 0; bad_syn = 0; bad_data = 0;
        for (int v = 0; v < 2048; v++) begin
            drive_cycle(16'(v), 1'b0);
            exp = sb.pop_front();
            o = bus.d_out;
            cw[v] = o;
            if (o !== exp) begin
                bad_match++;
                if (bad_match < 4)
                    $display("FAIL b2b_%0d: got %h want %h", v, o, exp);
            end
            if ((^o) !== 1'b0) bad_par++;
            syn = 0;
            for (int pos = 1; pos < 16; pos++)
                if (o[pos] === 1'b1) syn = syn ^ pos;
            if (syn != 0) bad_syn++;
            j = 0;
            for (int pos = 1; pos < 16; pos++) begin
                if ((pos & (pos - 1)) != 0) begin
                    if (o[pos] !== v[j]) bad_data++;
                    j++;
                end
            end
        end
        tests++;
        if (bad_match != 0) begin
            fails++;
            $display("FAIL b2b_match: got %0d bad words want 0", bad_match);
        end
        tests++;
        if (bad_par != 0) begin
            fails++;
            $display("FAIL even_parity: got %0d odd words want 0", bad_par);
        end
        tests++;
        if (bad_syn != 0) begin
            fails++;
            $display("FAIL syndrome: got %0d nonzero want 0", bad_syn);
        end
        tests++;
        if (bad_data != 0) begin
            fails++;
            $display("FAIL data_pos: got %0d bad bits want 0", bad_data);
        end
        md = 16;
        for (int a = 0; a < 2048; a++)
            for (int b = a + 1; b < 2048; b++) begin
                int d;
                d = $countones(cw[a] ^ cw[b]);
                if (d < md) md = d;
            end
        tests++;
        if (md != 4) begin
            fails++;
            $display("FAIL min_distance: got %0d want 4", md);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] exp;
        logic [15:0] vals[6];
        logic r[6];
        vals[0] = 16'h0123; r[0] = 1'b0;
        vals[1] = 16'h0456; r[1] = 1'b0;
        vals[2] = 16'h07FF; r[2] = 1'b1;
        vals[3] = 16'h0789; r[3] = 1'b0;
        vals[4] = 16'h02AA; r[4] = 1'b0;
        vals[5] = 16'h0555; r[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(vals[i], r[i]);
            exp = sb.pop_front();
            tests++;
            if (bus.d_out !== exp) begin
                fails++;
                $display("FAIL mid_reset_%0d: got %h want %h", i, bus.d_out, exp);
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        bus.d_in = 16'h0000;
        test_reset();
        test_nibble_sweep();
        test_extremes();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
